// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path constants and the packed fetch entry type.
package riscv_pkg;
   localparam int INSTR_W = 32;
   localparam int PC_W = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/ifq_storage.sv
// ifq_storage: DEPTH-entry fetch entry register array, one write port and one
// asynchronous read port; contents are deliberately not reset.
module ifq_storage
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W = $bits(fetch_entry_t),
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: prefetch FIFO between fetch and decode with redirect flush.
// Define IFQ_BYPASS_EN for a zero-latency pass-through when the queue is empty.
module instr_fetch_queue
   import riscv_pkg::*;
#(
   parameter int INSTR_WIDTH = INSTR_W,
   parameter int N = PC_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     enq_valid,
   input  logic [INSTR_WIDTH-1:0]   enq_instr,
   input  logic [N-1:0]             enq_pc,
   output logic                     enq_ready,
   output logic                     deq_valid,
   output logic [INSTR_WIDTH-1:0]   deq_instr,
   output logic [N-1:0]             deq_pc,
   input  logic                     deq_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int W = INSTR_WIDTH + N;
   logic [AW:0] wr_ptr, rd_ptr;
   logic [W-1:0] head;
   logic empty, full, byp, enq_fire, deq_fire;
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign enq_ready = !full;
`ifdef IFQ_BYPASS_EN
   assign byp = empty && !flush && enq_valid;
`else
   assign byp = 1'b0;
`endif
   assign deq_valid = !empty || byp;
   assign deq_instr = !empty ? head[W-1:N] : byp ? enq_instr : INSTR_WIDTH'(NOP_INSTR);
   assign deq_pc = !empty ? head[N-1:0] : byp ? enq_pc : '0;
   // a bypassed entry consumed in the same cycle never touches storage
   assign enq_fire = enq_valid && !full && !(byp && deq_ready) && !flush;
   assign deq_fire = !empty && deq_ready && !flush;
   assign count = wr_ptr - rd_ptr;
   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (enq_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (deq_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   ifq_storage #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_storage (
      .clk   (clk),
      .we    (enq_fire),
      .waddr (wr_ptr[AW-1:0]),
      .wdata ({enq_instr, enq_pc}),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (head)
   );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed stimulus against a queue-based reference model,
// compared every falling edge, plus hand-computed literal checkpoints.
module tb_instr_fetch_queue;
   localparam int DEPTH = 4;
   logic clk = 0, n_reset = 0;
   logic enq_valid = 0, deq_ready = 0, flush = 0;
   logic [31:0] enq_instr = 0, enq_pc = 0;
   logic enq_ready, deq_valid;
   logic [31:0] deq_instr, deq_pc;
   logic [2:0] count;
   int n_cmp = 0, n_bad = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;
   ent_t mq[$];

   instr_fetch_queue #(.INSTR_WIDTH(32), .N(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .n_reset(n_reset), .enq_valid(enq_valid), .enq_instr(enq_instr),
      .enq_pc(enq_pc), .enq_ready(enq_ready), .deq_valid(deq_valid),
      .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_ready(deq_ready),
      .flush(flush), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit model_byp();
`ifdef IFQ_BYPASS_EN
      return mq.size() == 0 && enq_valid && !flush;
`else
      return 1'b0;
`endif
   endfunction

   always @(negedge clk) begin
      logic ev;
      logic [31:0] ei, ep;
      ev = mq.size() != 0 || model_byp();
      ei = mq.size() != 0 ? mq[0].instr : model_byp() ? enq_instr : 32'h13;
      ep = mq.size() != 0 ? mq[0].pc : model_byp() ? enq_pc : 32'h0;
      chk("deq_valid", deq_valid, ev);
      chk("deq_instr", deq_instr, ei);
      chk("deq_pc", deq_pc, ep);
      chk("count", count, mq.size());
      chk("enq_ready", enq_ready, mq.size() < DEPTH);
   end

   always @(posedge clk) begin
      if (!n_reset || flush) mq.delete();
      else if (!(model_byp() && deq_ready)) begin
         bit do_enq;
         do_enq = enq_valid && mq.size() < DEPTH;
         if (mq.size() != 0 && deq_ready) void'(mq.pop_front());
         if (do_enq) mq.push_back('{enq_instr, enq_pc});
      end
   end

   always @(negedge n_reset) mq.delete();

   task automatic step(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
      enq_valid = ev;
      enq_pc = pc;
      enq_instr = 32'hA000_0000 | pc;
      deq_ready = dr;
      flush = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      chk("rst_count", count, 0);
      chk("rst_valid", deq_valid, 0);
      chk("rst_instr", deq_instr, 32'h13);
      chk("rst_ready", enq_ready, 1);
      @(posedge clk); @(posedge clk); #1;
      n_reset = 1;
      // fill with decode stalled
      for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 0);
      chk("fill_count", count, 4);
      chk("fill_ready", enq_ready, 0);
      step(1, 32'h10, 0, 0);
      chk("refused_count", count, 4);
      for (int i = 0; i < 4; i++) begin
         enq_valid = 0; deq_ready = 1; #1;
         chk("drain_pc", deq_pc, 32'(i * 4));
         step(0, 0, 1, 0);
      end
      chk("drained_valid", deq_valid, 0);
      // streaming wrap-around
      for (int i = 0; i < 10; i++) begin
         step(1, 32'h100 + 32'(i * 4), 1, 0);
`ifndef IFQ_BYPASS_EN
         chk("stream_count", count, 1);
         chk("stream_pc", deq_pc, 32'h100 + 32'(i * 4));
`endif
      end
      step(0, 0, 1, 0);
      // full with simultaneous dequeue
      for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(i * 4), 0, 0);
      step(1, 32'h300, 1, 0);
      chk("fulldeq_count", count, 3);
      chk("fulldeq_pc", deq_pc, 32'h204);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      // flush with same-cycle enqueue
      for (int i = 0; i < 3; i++) step(1, 32'h20 + 32'(i * 4), 0, 0);
      step(1, 32'h40, 0, 1);
      chk("flush_count", count, 0);
      chk("flush_valid", deq_valid, 0);
      chk("flush_ready", enq_ready, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      // empty-queue enqueue with decode ready
      enq_valid = 1; enq_pc = 32'h10; enq_instr = 32'h0050_0093; deq_ready = 1; #1;
`ifdef IFQ_BYPASS_EN
      chk("byp_valid", deq_valid, 1);
      chk("byp_instr", deq_instr, 32'h0050_0093);
`else
      chk("nobyp_valid", deq_valid, 0);
`endif
      @(posedge clk); #1;
      enq_valid = 0; deq_ready = 0; #1;
`ifdef IFQ_BYPASS_EN
      chk("byp_count", count, 0);
`else
      chk("nobyp_next_valid", deq_valid, 1);
      chk("nobyp_next_pc", deq_pc, 32'h10);
`endif
      step(0, 0, 1, 0);
      // asynchronous reset mid-stream
      step(1, 32'h500, 0, 0);
      step(1, 32'h504, 0, 0);
      #2 n_reset = 0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_valid", deq_valid, 0);
      chk("arst_pc", deq_pc, 0);
      chk("arst_ready", enq_ready, 1);
      @(posedge clk); #1;
      n_reset = 1;
      step(1, 32'h600, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
